// File: rtl/cpu_load_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_load_scoreboard_if
// Description : Bundles the ID-stage issue signals, the memory response
//               signals and the scoreboard stall/status outputs.
// Ports       : none (signal bundle only)
//   master : pipeline side, drives ID/EX/response inputs, reads stall/status
//   slave  : scoreboard side, the mirror image of master
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_load_scoreboard_if #(
  parameter int REG_W   = 5,
  parameter int ENTRIES = 4
);
  localparam int CNT_W = $clog2(ENTRIES + 1);

  logic             id_valid;
  logic [REG_W-1:0] ra_id;
  logic [REG_W-1:0] rb_id;
  logic             uses_ra;
  logic             uses_rb;
  logic [REG_W-1:0] rd_id;
  logic             writeback_id;
  logic             is_load_id;
  logic             ex_ready;
  logic             ld_done;
  logic [REG_W-1:0] ld_done_rd;
  logic             stall_id;
  logic             bubble_ex;
  logic [CNT_W-1:0] ld_count;
  logic             sb_error;

  modport master (
    output id_valid, ra_id, rb_id, uses_ra, uses_rb, rd_id, writeback_id,
           is_load_id, ex_ready, ld_done, ld_done_rd,
    input  stall_id, bubble_ex, ld_count, sb_error
  );

  modport slave (
    input  id_valid, ra_id, rb_id, uses_ra, uses_rb, rd_id, writeback_id,
           is_load_id, ex_ready, ld_done, ld_done_rd,
    output stall_id, bubble_ex, ld_count, sb_error
  );
endinterface
`default_nettype wire

// File: rtl/cpu_load_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : cpu_load_scoreboard
// Description : Tracks destination registers of loads still in flight and
//               stalls ID on RAW/WAW collisions with them or when no tracking
//               slot is free for a new load.
// Ports       :
//   clk_i          : clock, rising edge
//   rst_ni         : asynchronous active-low reset
//   bus            : cpu_load_scoreboard_if.slave (issue, response, status)
//   stall_cycles_o : cycles with stall asserted (CPU_SCOREBOARD_STATS_EN only)
//   full_cycles_o  : cycles stalled only by a full table (STATS_EN only)
// Options     : define CPU_SCOREBOARD_STATS_EN to add the stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_load_scoreboard #(
  parameter int REG_W   = 5,
  parameter int ENTRIES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cpu_load_scoreboard_if.slave bus
`ifdef CPU_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]          stall_cycles_o,
  output logic [15:0]          full_cycles_o
`endif
);
  localparam int CNT_W = $clog2(ENTRIES + 1);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [REG_W-1:0]   rd_q [ENTRIES];
  logic [REG_W-1:0]   rd_d [ENTRIES];
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;

  logic [ENTRIES-1:0] freed;   // slot retired by this cycle's response
  logic [ENTRIES-1:0] live;    // valid and not retired this cycle
  logic               match_ra, match_rb, match_rd;
  logic               raw, waw, full, stall, issue, alloc, any_freed, found;

  always_comb begin
    freed    = '0;
    match_ra = 1'b0;
    match_rb = 1'b0;
    match_rd = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      freed[i] = bus.ld_done && valid_q[i] && (rd_q[i] == bus.ld_done_rd) &&
                 (bus.ld_done_rd != '0);
    end
    // A returning load is forwarded by write-back, so it no longer blocks.
    live = valid_q & ~freed;
    for (int i = 0; i < ENTRIES; i++) begin
      if (live[i]) begin
        if (rd_q[i] == bus.ra_id) match_ra = 1'b1;
        if (rd_q[i] == bus.rb_id) match_rb = 1'b1;
        if (rd_q[i] == bus.rd_id) match_rd = 1'b1;
      end
    end
    match_ra = match_ra && (bus.ra_id != '0);
    match_rb = match_rb && (bus.rb_id != '0);
    match_rd = match_rd && (bus.rd_id != '0);

    raw   = (bus.uses_ra && match_ra) || (bus.uses_rb && match_rb);
    waw   = bus.writeback_id && match_rd;
    full  = bus.is_load_id && (&live);
    stall = bus.id_valid && (raw || waw || full);
    issue = bus.id_valid && !stall && bus.ex_ready;
    alloc = issue && bus.is_load_id && bus.writeback_id && (bus.rd_id != '0);

    // Free first, then allocate into the lowest free slot (may be the one
    // just retired).
    valid_d = live;
    rd_d    = rd_q;
    found   = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (alloc && !found && !live[i]) begin
        valid_d[i] = 1'b1;
        rd_d[i]    = bus.rd_id;
        found      = 1'b1;
      end
    end

    any_freed = |freed;
    count_d   = count_q + CNT_W'(alloc) - CNT_W'(any_freed);
    err_d     = err_q || (bus.ld_done && !any_freed);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) rd_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      err_q   <= err_d;
      for (int i = 0; i < ENTRIES; i++) rd_q[i] <= rd_d[i];
    end
  end

  assign bus.stall_id  = stall;
  assign bus.bubble_ex = stall;
  assign bus.ld_count  = count_q;
  assign bus.sb_error  = err_q;

`ifdef CPU_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] full_cycles_q;
  logic        full_only;

  assign full_only = full && !raw && !waw;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cycles_q <= '0;
      full_cycles_q  <= '0;
    end else begin
      if (stall && (stall_cycles_q != '1))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (stall && full_only && (full_cycles_q != '1))
        full_cycles_q <= full_cycles_q + 16'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign full_cycles_o  = full_cycles_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_cpu_load_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_load_scoreboard
// Description : Directed, table-driven bench for cpu_load_scoreboard
//               (REG_W=5, ENTRIES=4), with hand sequences for mid-operation
//               reset and the optional CPU_SCOREBOARD_STATS_EN counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_load_scoreboard;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_load_scoreboard_if #(.REG_W(5), .ENTRIES(4)) sb_if ();

`ifdef CPU_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] full_cycles;
`endif

  cpu_load_scoreboard #(.REG_W(5), .ENTRIES(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (sb_if)
`ifdef CPU_SCOREBOARD_STATS_EN
    ,
    .stall_cycles_o (stall_cycles),
    .full_cycles_o  (full_cycles)
`endif
  );

  typedef struct {
    logic       idv;
    logic [4:0] ra;
    logic       ua;
    logic [4:0] rb;
    logic       ub;
    logic [4:0] rd;
    logic       wb;
    logic       ld;
    logic       exr;
    logic       dn;
    logic [4:0] dn_rd;
    logic       exp_stall;
    logic [2:0] exp_cnt;   // ld_count after the clock edge
    logic       exp_err;   // sb_error after the clock edge
  } vec_t;

  vec_t vt[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(int idv, int ra, int ua, int rb, int ub, int rd,
                              int wb, int ld, int exr, int dn, int dn_rd,
                              int st, int cnt, int err);
    vec_t v;
    v.idv = 1'(idv); v.ra = 5'(ra); v.ua = 1'(ua); v.rb = 5'(rb);
    v.ub = 1'(ub); v.rd = 5'(rd); v.wb = 1'(wb); v.ld = 1'(ld);
    v.exr = 1'(exr); v.dn = 1'(dn); v.dn_rd = 5'(dn_rd);
    v.exp_stall = 1'(st); v.exp_cnt = 3'(cnt); v.exp_err = 1'(err);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sb_if.id_valid     = v.idv;
    sb_if.ra_id        = v.ra;
    sb_if.uses_ra      = v.ua;
    sb_if.rb_id        = v.rb;
    sb_if.uses_rb      = v.ub;
    sb_if.rd_id        = v.rd;
    sb_if.writeback_id = v.wb;
    sb_if.is_load_id   = v.ld;
    sb_if.ex_ready     = v.exr;
    sb_if.ld_done      = v.dn;
    sb_if.ld_done_rd   = v.dn_rd;
  endtask

  // Apply one vector for one cycle: check stall/bubble before the edge,
  // then count/error just after it.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, " stall_id"},  32'(sb_if.stall_id),  32'(v.exp_stall));
    chk({tag, " bubble_ex"}, 32'(sb_if.bubble_ex), 32'(v.exp_stall));
    @(posedge clk);
    #1;
    chk({tag, " ld_count"},  32'(sb_if.ld_count),  32'(v.exp_cnt));
    chk({tag, " sb_error"},  32'(sb_if.sb_error),  32'(v.exp_err));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0));
    rst_n = 1'b0;
    #1;
    chk("reset ld_count", 32'(sb_if.ld_count), 32'd0);
    chk("reset sb_error", 32'(sb_if.sb_error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //    idv ra ua rb ub rd wb ld ex dn drd  st cnt err
    // load-use
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0));
    vt.push_back(mk(1,0,0,0,0,5,1,1,1,0,0, 0,1,0));
    vt.push_back(mk(1,5,1,0,0,8,1,0,1,0,0, 1,1,0));
    vt.push_back(mk(1,5,1,0,0,8,1,0,1,1,5, 0,0,0));
    // fill the table, fifth load stalls, then reuses the slot freed by rd=2
    for (int k = 1; k <= 4; k++) vt.push_back(mk(1,0,0,0,0,k,1,1,1,0,0, 0,k,0));
    vt.push_back(mk(1,0,0,0,0,6,1,1,1,0,0, 1,4,0));
    vt.push_back(mk(1,0,0,0,0,6,1,1,1,1,2, 0,4,0));
    vt.push_back(mk(1,6,1,0,0,0,0,0,1,0,0, 1,4,0));
    vt.push_back(mk(1,2,1,3,0,0,0,0,1,0,0, 0,4,0));
    vt.push_back(mk(1,0,0,4,1,0,0,0,1,0,0, 1,4,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,1,1, 0,3,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,1,6, 0,2,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,1,3, 0,1,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,1,4, 0,0,0));
    // WAW, same-cycle free+realloc of one register, ex_ready backpressure
    vt.push_back(mk(1,0,0,0,0,7,1,1,1,0,0, 0,1,0));
    vt.push_back(mk(1,0,0,0,0,7,1,0,1,0,0, 1,1,0));
    vt.push_back(mk(1,0,0,0,0,7,0,0,1,0,0, 0,1,0));
    vt.push_back(mk(1,0,0,0,0,7,1,1,1,1,7, 0,1,0));
    vt.push_back(mk(1,0,0,0,0,9,1,1,0,0,0, 0,1,0));
    vt.push_back(mk(1,7,1,0,0,0,0,0,0,0,0, 1,1,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,1,7, 0,0,0));
    // register zero and untracked loads
    vt.push_back(mk(1,0,0,0,0,0,1,1,1,0,0, 0,0,0));
    vt.push_back(mk(1,0,1,0,1,0,1,0,1,0,0, 0,0,0));
    vt.push_back(mk(1,0,0,0,0,5,0,1,1,0,0, 0,0,0));
    // id_valid=0 and unused source never stall
    vt.push_back(mk(1,0,0,0,0,3,1,1,1,0,0, 0,1,0));
    vt.push_back(mk(0,3,1,0,0,3,1,0,1,0,0, 0,1,0));
    vt.push_back(mk(1,3,0,0,0,8,1,0,1,0,0, 0,1,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,1,3, 0,0,0));
    // stray responses raise a sticky error
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,1,9, 0,0,1));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,1));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 0,0,1));

    drive(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("por ld_count", 32'(sb_if.ld_count), 32'd0);
    chk("por sb_error", 32'(sb_if.sb_error), 32'd0);
    chk("por stall_id", 32'(sb_if.stall_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) step(vt[i], $sformatf("v%0d", i));

    // reset with three loads pending; responses after release are stray
    step(mk(1,0,0,0,0,10,1,1,1,0,0, 0,1,1), "rs0");
    step(mk(1,0,0,0,0,11,1,1,1,0,0, 0,2,1), "rs1");
    step(mk(1,0,0,0,0,12,1,1,1,0,0, 0,3,1), "rs2");
    pulse_reset();
    step(mk(1,10,1,0,0,0,0,0,1,0,0, 0,0,0), "rs3");
    step(mk(0,0,0,0,0,0,0,0,0,1,10, 0,0,1), "rs4");

`ifdef CPU_SCOREBOARD_STATS_EN
    pulse_reset();
    chk("stats reset stall_cycles", stall_cycles, 32'd0);
    chk("stats reset full_cycles",  32'(full_cycles), 32'd0);
    step(mk(1,0,0,0,0,5,1,1,1,0,0, 0,1,0), "st0");
    for (int k = 0; k < 10; k++)
      step(mk(1,5,1,0,0,8,1,0,1,0,0, 1,1,0), $sformatf("st_raw%0d", k));
    chk("stats raw stall_cycles", stall_cycles, 32'd10);
    chk("stats raw full_cycles",  32'(full_cycles), 32'd0);
    for (int k = 2; k <= 4; k++)
      step(mk(1,0,0,0,0,k,1,1,1,0,0, 0,k,0), $sformatf("st_ld%0d", k));
    for (int k = 0; k < 3; k++)
      step(mk(1,0,0,0,0,6,1,1,1,0,0, 1,4,0), $sformatf("st_full%0d", k));
    chk("stats full stall_cycles", stall_cycles, 32'd13);
    chk("stats full full_cycles",  32'(full_cycles), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cpu_load_scoreboard.md
Name: cpu_load_scoreboard

Overview:
- Producer-side counterpart to the operand forwarding logic.
- Tracks destination registers of loads that are still in flight, i.e. not yet in any stage the bypass network can forward from.
- Stalls ID when a source or destination register collides with a pending load, or when no tracking slot is free.
- Sits between the ID stage issue point and the memory response path.

Parameters:
- REG_W, 5, register index width; register 0 is hardwired zero and never causes a hazard.
- ENTRIES, 4, number of in-flight load slots (2..8).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- id_valid  in  1  ID holds a valid instruction.
- ra_id  in  REG_W  source A index.
- rb_id  in  REG_W  source B index.
- uses_ra  in  1  instruction reads ra_id.
- uses_rb  in  1  instruction reads rb_id.
- rd_id  in  REG_W  destination index.
- writeback_id  in  1  instruction writes rd_id.
- is_load_id  in  1  instruction is a load.
- ex_ready  in  1  EX accepts an instruction this cycle.
- ld_done  in  1  a load response returns this cycle.
- ld_done_rd  in  REG_W  destination of the returning load.
- stall_id  out  1  hold ID and PC (combinational).
- bubble_ex  out  1  inject a NOP into EX (combinational).
- ld_count  out  $clog2(ENTRIES+1)  number of valid slots (registered).
- sb_error  out  1  sticky protocol error flag (registered).

Behaviour:
- State: per slot, valid bit plus REG_W-bit rd. Reset: all slots invalid, ld_count=0, sb_error=0.
- Freed-this-cycle: the slot matching ld_done_rd when ld_done=1. It counts as not pending for hazard checks in the same cycle, because the write-back path forwards the data.
- Pending match on register r: some valid, not-freed slot has rd==r, and r!=0.
- stall_id = id_valid & (raw | waw | full):
  - raw: (uses_ra & match ra_id) | (uses_rb & match rb_id).
  - waw: writeback_id & match rd_id.
  - full: is_load_id & every slot valid and not freed.
- bubble_ex = stall_id.
- issue = id_valid & !stall_id & ex_ready.
- Allocate on issue & is_load_id & writeback_id & rd_id!=0: take the lowest-index free slot (freed-this-cycle slots count as free), set valid, store rd_id. A load with rd_id=0 is not tracked.
- Free on ld_done: invalidate the matching slot at the clock edge. WAW stall guarantees at most one slot matches.
- ld_done with no matching valid slot (or ld_done_rd=0): no state change; sb_error set to 1, and held until reset.
- ld_done and allocation in the same cycle: free first, then allocate. The same slot may be reused in that cycle.
- ld_count updates the cycle after a change; net change per cycle is -1, 0 or +1.
- ex_ready=0 does not raise stall_id (upstream backpressure is handled elsewhere), but it blocks allocation.
- Reset asserted mid-operation: all slots drop immediately. Any responses arriving after reset release raise sb_error.

Optional Feature:
- Macro: CPU_SCOREBOARD_STATS_EN.
- Defined:
  - Adds output stall_cycles[31:0], incremented on every cycle stall_id=1 and saturating at 0xFFFFFFFF.
  - Adds output full_cycles[15:0], incremented when the stall is caused only by full, also saturating.
  - Both counters reset to 0.
- Undefined: neither port nor its counter logic exists; all other behaviour is identical.

Test Plan:
- Load-use: issue load rd=5; next cycle ra_id=5, uses_ra=1, no ld_done -> stall_id=1, bubble_ex=1. Pulse ld_done rd=5 -> stall_id=0 in that same cycle; ld_count goes 1 -> 0.
- Full table (ENTRIES=4): issue loads rd=1,2,3,4 -> ld_count=4. Fifth load rd=6 -> stall_id=1. ld_done rd=2 in that cycle -> load issues and reuses slot 1; ld_count stays 4.
- WAW: pending load rd=7; ALU op with rd=7, writeback_id=1 -> stall_id=1. Same op with writeback_id=0 -> stall_id=0.
- Register zero: load rd=0 is not tracked (ld_count stays 0). Consumer with ra_id=0 never stalls.
- Error and reset: ld_done rd=9 with no pending slot -> sb_error=1 next cycle, stays 1. Assert reset with 3 slots valid -> ld_count=0 and sb_error=0 immediately.
- Stats (CPU_SCOREBOARD_STATS_EN): hold a RAW stall for 10 cycles -> stall_cycles=10, full_cycles=0. Hold a full-only stall for 3 cycles -> stall_cycles=13, full_cycles=3.
